// File: rtl/alu_pipe.sv
// alu_pipe: two-stage Hack-style ALU with valid/ready handshake and an
// accumulator operand. S1 holds the accepted operation; S2 holds the result.
// Ports:
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready   operation handshake (c, acc_en, x, y)
//   c[1:6]              zx, nx, zy, ny, f, no
//   acc_en              use accumulator in place of y
//   out_valid/out_ready result handshake (out, zr, ng, cy, ov)
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:6]       c,
  input  logic             acc_en,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov
);

  localparam int MSB = WIDTH - 1;

  logic             s1_valid_q;
  logic [1:6]       s1_c_q;
  logic             s1_acc_q;
  logic [WIDTH-1:0] s1_x_q;
  logic [WIDTH-1:0] s1_y_q;

  logic [WIDTH-1:0] acc_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_q;
  logic             zr_q;
  logic             ng_q;
  logic             cy_q;
  logic             ov_q;

  logic             s2_free;
  logic             s2_load;
  logic             accept;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] out_d;
  logic             zr_d;
  logic             ng_d;
  logic             cy_d;
  logic             ov_d;

  // S2 can take a new result when it is empty or draining this cycle.
  assign s2_free  = !out_valid_q || out_ready;
  assign s2_load  = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign accept   = in_valid && in_ready;

  always_comb begin
    a = s1_c_q[1] ? '0 : s1_x_q;
    a = s1_c_q[2] ? ~a : a;
    // The accumulator already holds the previous result when the
    // dependent op sits in S1, so no forwarding path is needed.
    b = s1_acc_q ? acc_q : s1_y_q;
    b = s1_c_q[3] ? '0 : b;
    b = s1_c_q[4] ? ~b : b;
    {carry, sum} = {1'b0, a} + {1'b0, b};
    r     = s1_c_q[5] ? sum : (a & b);
    out_d = s1_c_q[6] ? ~r : r;
    zr_d  = (out_d == '0);
    ng_d  = out_d[MSB];
    // Flags describe the adder, so they ignore the final inversion.
    cy_d  = s1_c_q[5] & carry;
    ov_d  = s1_c_q[5] & (a[MSB] == b[MSB])
                      & (sum[MSB] != a[MSB]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_c_q     <= '0;
      s1_acc_q   <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (accept) begin
        s1_c_q   <= c;
        s1_acc_q <= acc_en;
        s1_x_q   <= x;
        s1_y_q   <= y;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zr_q        <= 1'b0;
      ng_q        <= 1'b0;
      cy_q        <= 1'b0;
      ov_q        <= 1'b0;
      acc_q       <= '0;
    end else begin
      if (s2_free) out_valid_q <= s1_valid_q;
      if (s2_load) begin
        out_q <= out_d;
        zr_q  <= zr_d;
        ng_q  <= ng_d;
        cy_q  <= cy_d;
        ov_q  <= ov_d;
        acc_q <= out_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
  assign cy        = cy_q;
  assign ov        = ov_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against
// an arithmetic reference model and an in-order result queue.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:6]  c;
  logic        acc_en;
  logic [15:0] x;
  logic [15:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        zr;
  logic        ng;
  logic        cy;
  logic        ov;

  alu_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c         (c),
    .acc_en    (acc_en),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
    .ng        (ng),
    .cy        (cy),
    .ov        (ov)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] o;
    logic [3:0]  f;
    int          acyc;
  } exp_t;

  typedef struct {
    logic [15:0] o;
    logic [3:0]  f;
    int          lat;
    int          cyc;
  } obs_t;

  exp_t        expq[$];
  obs_t        obs[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [15:0] macc;
  logic        hold_pend;
  logic [19:0] hold_val;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Reference: plain integer arithmetic on the documented rules.
  function automatic exp_t model(input logic [1:6] cc,
                                 input logic [15:0] xa,
                                 input logic [15:0] yb);
    int   a, b, s, sa, sb, r;
    logic fc, fo;
    exp_t e;
    a  = cc[1] ? 0 : int'(xa);
    if (cc[2]) a = 65535 - a;
    b  = cc[3] ? 0 : int'(yb);
    if (cc[4]) b = 65535 - b;
    fc = 1'b0;
    fo = 1'b0;
    if (cc[5]) begin
      s  = a + b;
      r  = s % 65536;
      fc = (s > 65535);
      sa = (a > 32767) ? a - 65536 : a;
      sb = (b > 32767) ? b - 65536 : b;
      fo = (sa + sb > 32767) || (sa + sb < -32768);
    end else begin
      r = a & b;
    end
    if (cc[6]) r = 65535 - r;
    e.o    = r[15:0];
    e.f    = {r == 0, r > 32767, fc, fo};
    e.acyc = 0;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk or posedge rst) begin
    exp_t e;
    obs_t ob;
    if (rst) begin
      expq.delete();
      macc      = '0;
      hold_pend = 1'b0;
    end else begin
      if (hold_pend)
        check("hold", 64'({out, zr, ng, cy, ov}), 64'(hold_val));
      hold_pend = out_valid && !out_ready;
      hold_val  = {out, zr, ng, cy, ov};
      if (out_valid && out_ready) begin
        check("expq_nonempty", 64'(expq.size() > 0), 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          check("out", 64'(out), 64'(e.o));
          check("flags", 64'({zr, ng, cy, ov}), 64'(e.f));
          ob.o   = out;
          ob.f   = {zr, ng, cy, ov};
          ob.lat = cyc - e.acyc;
          ob.cyc = cyc;
          obs.push_back(ob);
        end
      end
      if (in_valid && in_ready) begin
        e      = model(c, x, acc_en ? macc : y);
        macc   = e.o;
        e.acyc = cyc;
        expq.push_back(e);
      end
    end
  end

  task automatic issue(input logic [1:6] cc, input logic ae,
                       input logic [15:0] xv, input logic [15:0] yv);
    logic ok;
    ok       = 1'b0;
    c        = cc;
    acc_en   = ae;
    x        = xv;
    y        = yv;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("issue_timeout", 64'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_obs(input int i, input string tag,
                            input logic [15:0] o,
                            input logic [3:0] f);
    check({tag, "_present"}, 64'(obs.size() > i), 1);
    if (obs.size() > i) begin
      check({tag, "_out"}, 64'(obs[i].o), 64'(o));
      check({tag, "_flags"}, 64'(obs[i].f), 64'(f));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    c         = '0;
    acc_en    = 1'b0;
    x         = '0;
    y         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out", 64'(out), 0);
    check("rst_flags", 64'({zr, ng, cy, ov}), 0);
    check("rst_in_ready", 64'(in_ready), 1);
    rst = 1'b0;
    idle(1);

    // Constant-producing control words and latency.
    obs.delete();
    issue(6'b101010, 1'b0, 16'h1234, 16'h5678);
    issue(6'b111111, 1'b0, 16'h1234, 16'h5678);
    issue(6'b111010, 1'b0, 16'h1234, 16'h5678);
    idle(4);
    expect_obs(0, "zero", 16'h0000, 4'b1000);
    expect_obs(1, "one", 16'h0001, 4'b0010);
    expect_obs(2, "neg1", 16'hffff, 4'b0100);
    if (obs.size() > 0) check("latency", 64'(obs[0].lat), 2);

    // Add, and, overflow, subtract.
    obs.delete();
    issue(6'b000010, 1'b0, 16'hffff, 16'hf0f0);
    issue(6'b000000, 1'b0, 16'hffff, 16'hf0f0);
    issue(6'b000010, 1'b0, 16'h7fff, 16'h0001);
    issue(6'b010011, 1'b0, 16'h0005, 16'h0007);
    idle(4);
    expect_obs(0, "add_cy", 16'hf0ef, 4'b0110);
    expect_obs(1, "and", 16'hf0f0, 4'b0100);
    expect_obs(2, "add_ov", 16'h8000, 4'b0101);
    expect_obs(3, "x_minus_y", 16'hfffe, 4'b0110);

    // Backpressure: two accepts, then stall.
    obs.delete();
    out_ready = 1'b0;
    issue(6'b000010, 1'b0, 16'h0100, 16'h0001);
    issue(6'b000010, 1'b0, 16'h0200, 16'h0001);
    c        = 6'b000010;
    acc_en   = 1'b0;
    x        = 16'h0300;
    y        = 16'h0001;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue(6'b000010, 1'b0, 16'h0300, 16'h0001);
    issue(6'b000010, 1'b0, 16'h0400, 16'h0001);
    idle(5);
    check("bp_count", 64'(obs.size()), 4);
    expect_obs(0, "bp0", 16'h0101, 4'b0000);
    expect_obs(1, "bp1", 16'h0201, 4'b0000);
    expect_obs(2, "bp2", 16'h0301, 4'b0000);
    expect_obs(3, "bp3", 16'h0401, 4'b0000);

    // Reset between edges with two ops in flight.
    out_ready = 1'b0;
    issue(6'b000010, 1'b0, 16'h0011, 16'h0022);
    issue(6'b000010, 1'b0, 16'h0033, 16'h0044);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 0);
    check("mid_rst_out", 64'(out), 0);
    check("mid_rst_in_ready", 64'(in_ready), 1);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    obs.delete();
    idle(6);
    check("stale_results", 64'(obs.size()), 0);
    check("stale_out_valid", 64'(out_valid), 0);

    // Accumulator chain from a fresh reset.
    obs.delete();
    issue(6'b000010, 1'b1, 16'h0001, 16'h1234);
    issue(6'b000010, 1'b1, 16'h0001, 16'h1234);
    issue(6'b000010, 1'b1, 16'h0001, 16'h1234);
    idle(4);
    expect_obs(0, "chain0", 16'h0001, 4'b0000);
    expect_obs(1, "chain1", 16'h0002, 4'b0000);
    expect_obs(2, "chain2", 16'h0003, 4'b0000);
    if (obs.size() > 2) begin
      check("chain_gap01", 64'(obs[1].cyc - obs[0].cyc), 1);
      check("chain_gap12", 64'(obs[2].cyc - obs[1].cyc), 1);
    end

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      c         = 6'($urandom);
      acc_en    = 1'($urandom);
      case ($urandom_range(0, 5))
        0:       x = 16'hffff;
        1:       x = 16'h7fff;
        2:       x = 16'h8000;
        default: x = 16'($urandom);
      endcase
      y = 16'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(6);
    check("drain_empty", 64'(expq.size()), 0);
    check("drain_out_valid", 64'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
